// File: rtl/icache_pkg.sv
// Shared types and geometry helpers for the instruction cache and its refill engine.
package icache_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FILL = 2'd2
    } refill_state_e;

    // Fields are sized for the widest supported address; users slice them to their own widths.
    typedef struct packed {
        logic [63:0] tag;
        logic [63:0] index;
        logic [63:0] offset;
    } line_addr_t;

    function automatic int off_width(input int line_words);
        return $clog2(line_words);
    endfunction

    function automatic int idx_width(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_width(input int addr_w, input int sets, input int line_words);
        return addr_w - $clog2(sets) - $clog2(line_words) - 2;
    endfunction

    function automatic int way_width(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic line_addr_t split_addr(input logic [63:0] addr, input int off_w, input int idx_w);
        line_addr_t  la;
        logic [63:0] word;
        word      = addr >> 2;
        la.offset = word & ((64'd1 << off_w) - 64'd1);
        la.index  = (word >> off_w) & ((64'd1 << idx_w) - 64'd1);
        la.tag    = word >> (off_w + idx_w);
        return la;
    endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// Refill engine: owns the miss FSM, beat counter, latched line address and the memory handshake.
import icache_pkg::*;

module icache_refill_fsm #(
    parameter int ADDR_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int WAYS       = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            miss_i,
    input  logic [ADDR_W-1:0]               miss_addr_i,
    input  logic [way_width(WAYS)-1:0]      victim_i,
    input  logic                            flush_i,
    input  logic                            mem_ready_i,
    input  logic                            mem_rvalid_i,
    output logic                            mem_req_o,
    output logic [ADDR_W-1:0]               mem_addr_o,
    output logic                            busy_o,
    output logic                            beat_we_o,
    output logic [off_width(LINE_WORDS)-1:0] beat_idx_o,
    output logic                            line_done_o,
    output logic                            line_keep_o,
    output logic [ADDR_W-1:0]               line_base_o,
    output logic [way_width(WAYS)-1:0]      line_way_o
);
    localparam int OFF_W = off_width(LINE_WORDS);
    localparam int WAY_W = way_width(WAYS);
    localparam logic [OFF_W-1:0]  LAST_BEAT = OFF_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] LINE_MASK = ~(ADDR_W'(4 * LINE_WORDS - 1));

    refill_state_e     state_q, state_d;
    logic [OFF_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] base_q;
    logic [WAY_W-1:0]  way_q;
    logic              cancel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_o   = 1'b0;
        busy_o      = 1'b0;
        beat_we_o   = 1'b0;
        line_done_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (miss_i) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                busy_o    = 1'b1;
                mem_req_o = 1'b1;
                if (mem_ready_i) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                busy_o = 1'b1;
                if (mem_rvalid_i) begin
                    beat_we_o = 1'b1;
                    if (cnt_q == LAST_BEAT) begin
                        line_done_o = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A flush seen while the refill is in flight still lets the line land, but it must not become valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            base_q   <= '0;
            way_q    <= '0;
            cancel_q <= 1'b0;
        end else if (state_q == IDLE && miss_i) begin
            cnt_q    <= '0;
            base_q   <= miss_addr_i & LINE_MASK;
            way_q    <= victim_i;
            cancel_q <= 1'b0;
        end else begin
            if (beat_we_o) begin
                cnt_q <= cnt_q + OFF_W'(1);
            end
            if (busy_o && flush_i) begin
                cancel_q <= 1'b1;
            end
        end
    end

    assign mem_addr_o  = mem_req_o ? base_q : '0;
    assign beat_idx_o  = cnt_q;
    assign line_keep_o = ~cancel_q;
    assign line_base_o = base_q;
    assign line_way_o  = way_q;

endmodule

// File: rtl/instr_cache_refill.sv
// Set-associative L1 instruction cache: combinational hit path, flop arrays, round-robin refill.
// Defining ICACHE_PERF_CNT_EN adds saturating hit/miss counter outputs.
import icache_pkg::*;

module instr_cache_refill #(
    parameter int ADDR_W     = 32,
    parameter int WAYS       = 4,
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              flush_i,
    output logic [31:0]       instr_o,
    output logic              instr_valid_o,
    output logic              stall_o,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic              mem_ready_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]       hit_cnt_o,
    output logic [31:0]       miss_cnt_o
`endif
);
    localparam int OFF_W = off_width(LINE_WORDS);
    localparam int IDX_W = idx_width(SETS);
    localparam int TAG_W = tag_width(ADDR_W, SETS, LINE_WORDS);
    localparam int WAY_W = way_width(WAYS);

    logic [TAG_W-1:0] tag_q    [WAYS][SETS];
    logic [31:0]      data_q   [WAYS][SETS][LINE_WORDS];
    logic [SETS-1:0]  valid_q  [WAYS];
    logic [WAY_W-1:0] victim_q [SETS];

    line_addr_t       fetch_la;
    line_addr_t       fill_la;
    logic [TAG_W-1:0] fetch_tag;
    logic [TAG_W-1:0] fill_tag;
    logic [IDX_W-1:0] fetch_idx;
    logic [IDX_W-1:0] fill_idx;
    logic [OFF_W-1:0] fetch_off;
    logic             unused_addr_bits;

    logic              hit_any;
    logic [WAY_W-1:0]  hit_way;
    logic              lookup_hit;
    logic              lookup_miss;
    logic              busy;
    logic              beat_we;
    logic              line_done;
    logic              line_keep;
    logic [OFF_W-1:0]  beat_idx;
    logic [ADDR_W-1:0] line_base;
    logic [WAY_W-1:0]  line_way;

    assign fetch_la  = split_addr(64'(addr_i), OFF_W, IDX_W);
    assign fill_la   = split_addr(64'(line_base), OFF_W, IDX_W);
    assign fetch_tag = fetch_la.tag[TAG_W-1:0];
    assign fetch_idx = fetch_la.index[IDX_W-1:0];
    assign fetch_off = fetch_la.offset[OFF_W-1:0];
    assign fill_tag  = fill_la.tag[TAG_W-1:0];
    assign fill_idx  = fill_la.index[IDX_W-1:0];
    assign unused_addr_bits = ^{fetch_la.tag[63:TAG_W], fetch_la.index[63:IDX_W], fetch_la.offset[63:OFF_W],
                                fill_la.tag[63:TAG_W], fill_la.index[63:IDX_W], fill_la.offset};

    // Scan downward so the lowest-numbered matching way is the one left in hit_way.
    always_comb begin
        hit_any = 1'b0;
        hit_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (valid_q[w][fetch_idx] && tag_q[w][fetch_idx] == fetch_tag) begin
                hit_any = 1'b1;
                hit_way = WAY_W'(w);
            end
        end
    end

    assign lookup_hit    = ~busy & fetch_req_i & hit_any;
    assign lookup_miss   = ~busy & fetch_req_i & ~hit_any;
    assign instr_valid_o = lookup_hit;
    assign stall_o       = busy | lookup_miss;
    assign instr_o       = lookup_hit ? data_q[hit_way][fetch_idx][fetch_off] : 32'd0;

    icache_refill_fsm #(
        .ADDR_W     (ADDR_W),
        .LINE_WORDS (LINE_WORDS),
        .WAYS       (WAYS)
    ) u_refill (
        .clk          (clk),
        .rst_n        (rst_n),
        .miss_i       (lookup_miss),
        .miss_addr_i  (addr_i),
        .victim_i     (victim_q[fetch_idx]),
        .flush_i      (flush_i),
        .mem_ready_i  (mem_ready_i),
        .mem_rvalid_i (mem_rvalid_i),
        .mem_req_o    (mem_req_o),
        .mem_addr_o   (mem_addr_o),
        .busy_o       (busy),
        .beat_we_o    (beat_we),
        .beat_idx_o   (beat_idx),
        .line_done_o  (line_done),
        .line_keep_o  (line_keep),
        .line_base_o  (line_base),
        .line_way_o   (line_way)
    );

    always_ff @(posedge clk) begin
        if (beat_we) begin
            data_q[line_way][fill_idx][beat_idx] <= mem_rdata_i;
        end
        if (line_done) begin
            tag_q[line_way][fill_idx] <= fill_tag;
        end
    end

    // Flush wins over a completing refill so a line fetched across a fence.i never becomes valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
            end
        end else if (flush_i) begin
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
            end
        end else if (line_done && line_keep) begin
            valid_q[line_way][fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < SETS; s++) begin
                victim_q[s] <= '0;
            end
        end else if (line_done) begin
            victim_q[fill_idx] <= (victim_q[fill_idx] == WAY_W'(WAYS - 1)) ? '0
                                  : victim_q[fill_idx] + WAY_W'(1);
        end
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_o  <= '0;
            miss_cnt_o <= '0;
        end else begin
            if (lookup_hit && hit_cnt_o != 32'hFFFF_FFFF) begin
                hit_cnt_o <= hit_cnt_o + 32'd1;
            end
            if (lookup_miss && miss_cnt_o != 32'hFFFF_FFFF) begin
                miss_cnt_o <= miss_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/instr_cache_refill.md
Name: instr_cache_refill

Overview:
- Parametrised, set-associative L1 instruction cache with a real refill engine. It sits between the fetch stage and a multi-cycle instruction backing memory.
- Hits return the instruction combinationally in the same cycle.
- Misses stall fetch, burst-fill one full line over a valid/ready memory port, install the line, then replay the lookup.
- It is the successor to the single-cycle fixed-geometry cache-plus-memory system. It adds configurable ways, sets and line size, miss latency handling, a flush input and a stall output.

Parameters:
- ADDR_W, 32, byte address width.
- WAYS, 4, associativity; power of 2, from 1 to 8.
- SETS, 64, sets per way; power of 2, at least 2.
- LINE_WORDS, 4, 32-bit words per line; power of 2, from 2 to 16.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- fetch_req_i  in  1  fetch stage requests an instruction this cycle.
- addr_i  in  ADDR_W  fetch byte address; bits [1:0] are ignored.
- flush_i  in  1  invalidate the whole cache (fence.i).
- instr_o  out  32  fetched instruction.
- instr_valid_o  out  1  instr_o is valid this cycle.
- stall_o  out  1  fetch must hold addr_i and retry.
- mem_req_o  out  1  line read request to the backing memory.
- mem_addr_o  out  ADDR_W  line-aligned base address of the request.
- mem_ready_i  in  1  memory accepts the request.
- mem_rvalid_i  in  1  one refill beat is valid.
- mem_rdata_i  in  32  refill beat data, delivered in ascending word order.

Behaviour:
- Address split:
  - offset = addr[log2(LINE_WORDS)+1:2]
  - index = next log2(SETS) bits
  - tag = the remaining upper bits.
- Storage:
  - valid and tag arrays are flops.
  - data array is a flop array indexed by way, set and word. No memory macro.
  - one round-robin victim pointer per set, log2(WAYS) bits wide; unused when WAYS=1.
- Reset (async, rst_n low):
  - all valid bits, victim pointers, the beat counter and the FSM are cleared; FSM goes to IDLE.
  - outputs: instr_o=0, instr_valid_o=0, stall_o=0, mem_req_o=0, mem_addr_o=0.
  - data and tag arrays are not reset.
- FSM states:
  - IDLE:
    - lookup is combinational.
    - hit means fetch_req_i is high and any way has valid with a matching tag. On a hit: instr_valid_o=1, instr_o = the hit word, stall_o=0.
    - a miss with fetch_req_i high drives stall_o=1 the same cycle, latches the line address and victim way, and moves to REQ.
  - REQ: mem_req_o=1 and mem_addr_o = the latched line base. These hold stable until mem_ready_i is high, then the FSM moves to FILL.
  - FILL:
    - each mem_rvalid_i writes the beat to the victim way at beat index cnt, then cnt increments.
    - rvalid may have gaps.
    - the beat with cnt == LINE_WORDS-1 writes the tag, sets valid, advances that set's victim pointer (wrapping at WAYS), and moves to IDLE.
  - Back in IDLE, the lookup is replayed the next cycle and hits. Miss-to-valid latency is therefore REQ wait + LINE_WORDS beats + 1 cycle.
- stall_o is 1 in REQ and FILL, and combinationally 1 on an IDLE miss.
- instr_valid_o is 0 whenever stall_o is 1. It is also 0 when fetch_req_i is low.
- A new fetch is never accepted during REQ/FILL. addr_i changes there are ignored; the latched address is used.
- flush_i:
  - clears all valid bits next edge; victim pointers are unchanged.
  - flush_i in IDLE with a simultaneous fetch: that cycle's hit result is still returned, and the flush takes effect after the edge.
  - flush_i during REQ/FILL: the refill completes, but the valid bit is not set for that line. The replay then misses and refetches.
- mem_rvalid_i outside FILL is ignored.
- Multiple-way match (not reachable in legal operation): the lowest-numbered matching way wins.
- Reset mid-refill: the refill is abandoned immediately and mem_req_o drops asynchronously. The memory side must tolerate a dropped burst.

Optional Feature:
- ICACHE_PERF_CNT_EN defined:
  - adds outputs hit_cnt_o (32) and miss_cnt_o (32).
  - hit_cnt_o increments on each IDLE hit; miss_cnt_o increments on each IDLE-to-REQ transition.
  - both saturate at 0xFFFFFFFF, are cleared by reset, and are not cleared by flush_i.
- Not defined: the ports and counters are absent and there is no logic overhead.

Decomposition:
- Package icache_pkg holds:
  - the state enum typedef (IDLE, REQ, FILL).
  - localparam helper functions for offset, index and tag widths.
  - a line-address struct typedef {tag, index, offset}.
- One sub-module, icache_refill_fsm, owns the state, beat counter, latched line address and memory handshake. The top level holds the arrays, lookup and victim pointers.

Test Plan:
- Reset, then fetch 0x0000_0100: stall_o=1 and mem_addr_o=0x100. Memory returns 0x11,0x22,0x33,0x44 with ready after 2 cycles. Required: instr_valid_o=1 with instr_o=0x11 on the replay. A fetch of 0x10C then hits in the same cycle with 0x44.
- Set conflict with WAYS=4: fill 5 lines mapping to set 0. Ways are filled 0,1,2,3, then way 0 is evicted. The re-fetch of line 1 hits; the re-fetch of line 0 misses.
- Gapped refill: rvalid pattern 1,0,0,1,1,0,1. The line is installed only after the 4th beat, and stall_o stays high throughout.
- flush_i asserted during FILL: the refill completes, the replay misses, and a second memory request to the same address is issued.
- Async reset asserted mid-FILL: mem_req_o=0 and stall_o=0 immediately. The next fetch of the same address misses.
- With ICACHE_PERF_CNT_EN: 3 misses then 10 hits give miss_cnt_o=3 and hit_cnt_o=10.
